// File: rtl/sobol_pkg.sv
// Shared Sobol stochastic-computing defaults and the receiver FSM state type.
package sobol_pkg;
  localparam int DEF_DATA_W    = 6;
  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_CNT_W     = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/sobol_cmp_sng.sv
// Stochastic number generator: unsigned compare of a Sobol sample against the
// operand, registered with a one-cycle valid strobe. bit_out holds between strobes.
module sobol_cmp_sng #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] operand,
  output logic              bit_out,
  output logic              bit_valid
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      bit_valid <= valid;
      if (valid) bit_out <= (value < operand);
    end
  end
endmodule

// File: rtl/sobol_sc_receiver.sv
// Frame receiver: encodes x against FRAME_LEN Sobol samples and reports the
// count of ones per frame. x is latched at frame start and frozen until done.
module sobol_sc_receiver
  import sobol_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_value,
  input  logic [DATA_W-1:0] x,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [CNT_W-1:0]  result,
  output logic              done,
  output logic              busy
);
  state_t            state, state_nx;
  logic [DATA_W-1:0] x_lat, operand;
  logic [CNT_W-1:0]  cnt, ones, cnt_nx, ones_nx;
  logic              accept, b, last;

  assign accept  = en_in & in_valid;
  assign operand = (state == IDLE) ? x : x_lat;
  // The registered bit is a cycle late for the final sample, so the
  // accumulator uses its own copy of the compare.
  assign b       = (in_value < operand);
  assign cnt_nx  = ((state == IDLE) ? '0 : cnt) + CNT_W'(1);
  assign ones_nx = ((state == IDLE) ? '0 : ones) + CNT_W'(b);
  assign last    = (cnt_nx == CNT_W'(FRAME_LEN));
  assign busy    = (state == ACCUM);

  sobol_cmp_sng #(.DATA_W(DATA_W)) u_sng (
    .clk       (clk),
    .rst       (rst),
    .valid     (accept),
    .value     (in_value),
    .operand   (operand),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!en_in)       state_nx = IDLE;
    else if (accept)  state_nx = last ? IDLE : ACCUM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_lat  <= '0;
      cnt    <= '0;
      ones   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!en_in) begin
        x_lat <= '0;
        cnt   <= '0;
        ones  <= '0;
      end else begin
        if (state == IDLE) x_lat <= x;
        if (accept) begin
          if (last) begin
            result <= ones_nx;
            done   <= 1'b1;
            cnt    <= '0;
            ones   <= '0;
          end else begin
            cnt  <= cnt_nx;
            ones <= ones_nx;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sobol_sc_receiver.sv
// Directed bench for sobol_sc_receiver with bit/result scoreboards.
module tb_sobol_sc_receiver;
  localparam int DW = 6;
  localparam int FL = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en_in = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_value = '0;
  logic [DW-1:0] x = '0;
  logic          bit_out, bit_valid, done, busy;
  logic [CW-1:0] result;

  int checks = 0;
  int fails = 0;
  int cyc_n = 0;
  int done_cnt = 0;
  int done_t[$];
  bit bq[$];
  int rq[$];

  sobol_sc_receiver #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .x         (x),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .result    (result),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: pop expectations as the DUT produces bits and results.
  always @(negedge clk) begin
    if (bit_valid === 1'b1) begin
      chk("bitq_nonempty", 32'(bq.size() > 0), 32'd1);
      if (bq.size() > 0) chk("bit_out", 32'(bit_out), 32'(bq.pop_front()));
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_t.push_back(cyc_n);
      chk("resq_nonempty", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0) chk("result", 32'(result), 32'(rq.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [DW-1:0] v, input logic [DW-1:0] op);
    in_valid = 1'b1;
    in_value = v;
    bq.push_back(v < op);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] op, input int step, input int exp_res);
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1) rq.push_back(exp_res);
      strobe(DW'(i * step), op);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, t0;
    // Reset state
    #12;
    chk("rst_bit_out", 32'(bit_out), 32'd0);
    chk("rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    en_in = 1'b1;
    idle(2);

    // Ramp with a gap mid-frame
    x = 6'd32;
    d0 = done_cnt;
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1) rq.push_back(8);
      strobe(DW'(i * 4), 6'd32);
      if (i == 0) chk("ramp_busy", 32'(busy), 32'd1);
      if (i == 7) begin
        idle(3);
        chk("gap_bit_valid", 32'(bit_valid), 32'd0);
        chk("gap_bit_hold", 32'(bit_out), 32'd1);
        chk("gap_busy", 32'(busy), 32'd1);
      end
    end
    idle(2);
    chk("ramp_done_once", 32'(done_cnt - d0), 32'd1);
    chk("ramp_idle", 32'(busy), 32'd0);
    chk("ramp_result_hold", 32'(result), 32'd8);

    // Zero operand
    x = 6'd0;
    d0 = done_cnt;
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1) rq.push_back(0);
      strobe(DW'($urandom_range(0, 63)), 6'd0);
    end
    idle(2);
    chk("zero_done_once", 32'(done_cnt - d0), 32'd1);

    // Full operand
    x = 6'd63;
    d0 = done_cnt;
    frame(6'd63, 1, 16);
    idle(2);
    chk("full_done_once", 32'(done_cnt - d0), 32'd1);

    // Operand freeze: x moves to 0 after sample 3
    x = 6'd32;
    d0 = done_cnt;
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1) rq.push_back(8);
      strobe(DW'(i * 4), 6'd32);
      if (i == 2) x = 6'd0;
    end
    idle(2);
    chk("freeze_done_once", 32'(done_cnt - d0), 32'd1);

    // Abort after 7 samples; strobes while disabled are ignored
    x = 6'd32;
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) strobe(DW'(i * 4), 6'd32);
    en_in = 1'b0;
    in_valid = 1'b1;
    idle(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bit_valid", 32'(bit_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result_hold", 32'(result), 32'd8);
    idle(1);
    in_valid = 1'b0;
    en_in = 1'b1;
    x = 6'd16;
    frame(6'd16, 4, 4);
    idle(2);
    chk("abort_done_once", 32'(done_cnt - d0), 32'd1);

    // Back-to-back frames: frame B starts in the done cycle of frame A
    x = 6'd32;
    d0 = done_cnt;
    t0 = done_t.size();
    frame(6'd32, 4, 8);
    chk("b2b_done_cycle", 32'(done), 32'd1);
    x = 6'd63;
    frame(6'd63, 1, 16);
    idle(2);
    chk("b2b_done_twice", 32'(done_cnt - d0), 32'd2);
    if (done_t.size() >= t0 + 2)
      chk("b2b_spacing", 32'(done_t[t0+1] - done_t[t0]), 32'd16);
    else
      chk("b2b_times", 32'(done_t.size() - t0), 32'd2);

    // Reset mid-frame
    x = 6'd32;
    for (int i = 0; i < 5; i++) strobe(DW'(i * 4), 6'd32);
    idle(1);
    d0 = done_cnt;
    rst = 1'b0;
    #2;
    chk("mrst_bit_out", 32'(bit_out), 32'd0);
    chk("mrst_bit_valid", 32'(bit_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    for (int i = 0; i < FL - 1; i++) strobe(DW'(i * 4), 6'd32);
    idle(1);
    chk("mrst_no_early_done", 32'(done_cnt - d0), 32'd0);
    rq.push_back(8);
    strobe(DW'(60), 6'd32);
    idle(2);
    chk("mrst_done_once", 32'(done_cnt - d0), 32'd1);

    chk("bitq_drained", 32'(bq.size()), 32'd0);
    chk("resq_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
